// File: rtl/control_fsm.sv
// Multi-cycle control unit: FETCH/EXEC/MEM/HALT sequencer that decodes the
// current opcode into datapath strobes and keeps a circular return-address stack.
module control_fsm #(
  parameter int PC_W      = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      opcode,
  input  logic [3:0]      eoe,
  input  logic            Z,
  input  logic [PC_W-1:0] pc,
  input  logic            mem_ready,
  output logic            IL,
  output logic [1:0]      PS,
  output logic            MB,
  output logic [3:0]      FS,
  output logic            MD,
  output logic            RW,
  output logic            MW,
  output logic            MP,
  output logic [PC_W-1:0] ret_addr,
  output logic            halted,
  output logic            ras_ovf,
  output logic            ras_unf,
  output logic [1:0]      state
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    MEM   = 2'b10,
    HALT  = 2'b11
  } state_t;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_JUMP = 2'b10;
  localparam logic [1:0] PS_RET  = 2'b11;

  localparam logic [3:0] OP_LDI   = 4'b1000;
  localparam logic [3:0] OP_LD    = 4'b1001;
  localparam logic [3:0] OP_ST    = 4'b1010;
  localparam logic [3:0] OP_BZ    = 4'b1011;
  localparam logic [3:0] OP_BNZ   = 4'b1100;
  localparam logic [3:0] OP_JAL   = 4'b1101;
  localparam logic [3:0] OP_JMP   = 4'b1110;
  localparam logic [3:0] OP_RET   = 4'b1111;
  localparam logic [3:0] EOE_HALT = 4'b1111;

  state_t           cur_state;
  state_t           nxt_state;
  logic             mem_is_store;
  logic [PTR_W-1:0] top;
  logic [CNT_W-1:0] count;
  logic [PC_W-1:0]  entries [RAS_DEPTH];
  logic             ovf_flag;
  logic             unf_flag;

  logic             push;
  logic             pop;
  logic             set_unf;
  logic             mem_latch;
  logic             ras_empty;
  logic [PC_W-1:0]  ras_top;
  logic [PTR_W-1:0] top_inc;
  logic [PTR_W-1:0] top_dec;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  // A taken branch selects the offset path; a fall-through just increments.
  function automatic logic [1:0] branch_sel(input logic taken);
    return taken ? PS_JUMP : PS_INC;
  endfunction

  assign ras_empty = (count == '0);
  assign ras_top   = ras_empty ? '0 : entries[top];
  assign top_inc   = top + PTR_ONE;
  assign top_dec   = top - PTR_ONE;
  assign halted    = (cur_state == HALT);
  assign state     = cur_state;

  // Stage boundary: state, memory-op latch, RAS and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state    <= FETCH;
      mem_is_store <= 1'b0;
      top          <= '0;
      count        <= '0;
      ovf_flag     <= 1'b0;
      unf_flag     <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      cur_state <= nxt_state;
      if (mem_latch) begin
        mem_is_store <= (opcode == OP_ST);
      end
      if (push) begin
        entries[top_inc] <= pc;
        top              <= top_inc;
        if (count == CNT_FULL) begin
          ovf_flag <= 1'b1;
        end else begin
          count <= count + CNT_ONE;
        end
      end else if (pop) begin
        top   <= top_dec;
        count <= count - CNT_ONE;
      end
      if (set_unf) begin
        unf_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    nxt_state = cur_state;
    IL        = 1'b0;
    PS        = PS_HOLD;
    MB        = 1'b0;
    FS        = 4'b0000;
    MD        = 1'b0;
    RW        = 1'b0;
    MW        = 1'b0;
    MP        = 1'b0;
    ret_addr  = '0;
    ras_ovf   = 1'b0;
    ras_unf   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    set_unf   = 1'b0;
    mem_latch = 1'b0;

    if (!reset) begin
      if (cur_state != HALT) begin
        FS       = opcode;
        ret_addr = ras_top;
        ras_ovf  = ovf_flag;
        ras_unf  = unf_flag;
      end

      unique case (cur_state)
        FETCH: begin
          IL        = 1'b1;
          nxt_state = EXEC;
        end

        EXEC: begin
          nxt_state = FETCH;
          if (!opcode[3]) begin
            PS = PS_INC;
            RW = 1'b1;
          end else begin
            unique case (opcode)
              OP_LDI: begin
                MB = 1'b1;
                RW = 1'b1;
                PS = PS_INC;
              end
              OP_LD, OP_ST: begin
                MD        = (opcode == OP_LD);
                MW        = (opcode == OP_ST);
                mem_latch = is_mem_op(opcode);
                nxt_state = MEM;
              end
              OP_BZ:  PS = branch_sel(Z);
              OP_BNZ: PS = branch_sel(!Z);
              OP_JAL: begin
                PS   = PS_JUMP;
                RW   = 1'b1;
                MP   = 1'b1;
                push = 1'b1;
              end
              OP_JMP: PS = PS_JUMP;
              OP_RET: begin
                if (eoe == EOE_HALT) begin
                  nxt_state = HALT;
                end else if (!ras_empty) begin
                  PS  = PS_RET;
                  pop = 1'b1;
                end else begin
                  PS      = PS_INC;
                  set_unf = 1'b1;
                end
              end
              default: PS = PS_HOLD;
            endcase
          end
        end

        // The access direction comes from the bit latched in EXEC.
        MEM: begin
          MD = !mem_is_store;
          MW = mem_is_store;
          if (mem_ready) begin
            PS        = PS_INC;
            RW        = !mem_is_store;
            nxt_state = FETCH;
          end
        end

        HALT: nxt_state = HALT;

        default: nxt_state = FETCH;
      endcase
    end
  end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle control unit for the datapath. It generates IL/PS/MB/FS/MD/RW/MW/MP from the current instruction's opcode, and owns its own state register (FETCH/EXEC/MEM/HALT). It waits on a data-memory ready handshake for loads and stores, and keeps a parametrised return-address stack (RAS) for nested jump-and-link/return. It sits between the instruction register, the PC logic, the register file and the data memory.

## Interface
Parameters:
- PC_W, 8, width of PC values stored in the RAS and output on ret_addr
- RAS_DEPTH, 4, number of RAS entries (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  reset is synchronous and active-high
- opcode  in  4  instruction opcode from instruction register (stable while IL=0)
- eoe  in  4  end-of-execution field; 4'b1111 with opcode 1111 means halt
- Z  in  1  ALU zero flag
- pc  in  PC_W  current PC value, pushed on jump-and-link
- mem_ready  in  1  data memory completion for the pending load/store
- IL  out  1  instruction load
- PS  out  2  PC select: 00 hold, 01 increment, 10 branch/jump offset, 11 load ret_addr
- MB  out  1  immediate select
- FS  out  4  ALU function (= opcode)
- MD  out  1  memory-data select to register file
- RW  out  1  register write
- MW  out  1  memory write
- MP  out  1  write PC (link) into register file
- ret_addr  out  PC_W  RAS top entry; 0 when RAS empty
- halted  out  1  state == HALT
- ras_ovf  out  1  sticky: push while full
- ras_unf  out  1  sticky: pop while empty
- state  out  2  FETCH=00, EXEC=01, MEM=10, HALT=11

## Operation
- Outputs are combinational from state, opcode, Z, eoe, mem_ready, the latched memory-op bit and the RAS. Any output not listed below is 0. FS = opcode in every state except HALT and reset.
- FETCH: IL=1, PS=00. Next state EXEC.
- EXEC, opcode[3]=0 (ALU): PS=01, RW=1. Next state FETCH.
- EXEC, opcode 1000 (load immediate): MB=1, RW=1, PS=01. Next state FETCH.
- EXEC, opcode 1001 (load) or 1010 (store):
  - PS=00. Load asserts MD=1; store asserts MW=1.
  - Latch mem_is_store. Next state MEM.
  - mem_ready is ignored in EXEC.
- MEM:
  - Hold MD=1 (load) or MW=1 (store) every cycle.
  - While mem_ready=0: PS=00, stay in MEM.
  - On the mem_ready=1 cycle: PS=01, RW=1 for load only. Next state FETCH.
- EXEC, 1011 (BZ): PS = Z ? 10 : 01. EXEC, 1100 (BNZ): PS = Z ? 01 : 10. Next state FETCH.
- EXEC, 1101 (JAL): PS=10, RW=1, MP=1; push pc onto the RAS. Next state FETCH.
- EXEC, 1110 (JMP): PS=10. Next state FETCH.
- EXEC, 1111 with eoe==4'b1111: PS=00. Next state HALT.
- EXEC, 1111 otherwise (return):
  - RAS non-empty: PS=11 (ret_addr is the top entry this cycle); pop at the edge.
  - RAS empty: PS=01, set ras_unf, no pop.
  - Next state FETCH.
- HALT: all outputs 0 except halted=1 and state. Opcodes are ignored; only reset leaves HALT.
- RAS:
  - Circular buffer with top pointer of log2(RAS_DEPTH) bits and count 0..RAS_DEPTH.
  - Push: write the entry at top+1, advance top, increment count.
  - Push when full: overwrite the oldest entry (wrap), count stays at RAS_DEPTH, set ras_ovf.
  - Pop: retreat top, decrement count.
  - Push and pop never occur in the same cycle, because each opcode does at most one.

## Timing
- Instruction latency: ALU, LDI, branch, JAL, JMP and return take 2 cycles (FETCH, EXEC). Load/store take 3+N cycles, where N is the number of MEM cycles with mem_ready=0.
- PS/RW/MW/MP are sampled by the datapath at the same rising edge that advances state.
- RAS push/pop and flag set take effect at that edge. ret_addr reflects the new top on the next cycle.
- Reset: while reset=1, all outputs are forced to 0 (IL, PS, MB, FS, MD, RW, MW, MP, ret_addr).
- At the reset edge: state←FETCH, RAS count/top/entries←0, ras_ovf←0, ras_unf←0, mem_is_store←0.
- The first cycle after reset deasserts is FETCH (IL=1).
- Reset during MEM abandons the access: MW/MD drop in the reset cycle and no RW occurs. Reset in HALT returns to FETCH.
- Flags clear only on reset.

## Test plan
- Reset, then opcode 0011: FETCH cycle IL=1, PS=00 → EXEC cycle PS=01, RW=1, FS=0011 → FETCH; all other strobes 0.
- Load, mem_ready low 3 MEM cycles then high: MD=1 for 1 EXEC + 4 MEM cycles. RW=1 and PS=01 only in the ready cycle. Total 6 cycles to the next FETCH.
- JAL at pc=0x12, JAL at pc=0x34, return, return, return:
  - First return: PS=11, ret_addr=0x34.
  - Second return: PS=11, ret_addr=0x12.
  - Third return: PS=01, ras_unf=1, ret_addr=0.
- RAS_DEPTH=4, five JALs with pc=1..5: ras_ovf=1. Four returns yield ret_addr 5,4,3,2; the fifth return sets ras_unf.
- Opcode 1111, eoe=1111: next state HALT, halted=1, all strobes 0 for 10 cycles regardless of opcode. Reset then returns to FETCH.
- Store stalled in MEM, reset asserted: MW=0 during the reset cycle. After release, state=FETCH, RAS empty, flags 0.
